lsu: RTL and testbench
======================

# lsu

Load/store unit replacing the combinational memory stage between execute and writeback. It drives a data memory through a req/gnt/rvalid handshake, so the memory may be multi-cycle. It supports byte, halfword and word accesses with byte enables, sign or zero extension, and misalignment detection. While an access is outstanding it stalls the pipeline, and it registers the writeback value.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; must be 32 (size encoding 11 reserved)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- is_ld_op_passthrough  in  1  load in this stage
- is_str_op_passthrough  in  1  store in this stage (never both with load)
- size  in  2  00 byte, 01 half, 10 word, 11 illegal
- ld_unsigned  in  1  zero-extend loads when 1
- md_passthrough  in  ADDR_W  byte address
- rd_val_passthrough  in  DATA_W  store data, or result for non-memory ops
- stall  out  1  hold this stage's inputs and upstream
- misalign  out  1  one-cycle fault pulse
- wb_val  out  DATA_W  registered writeback value
- wb_valid  out  1  wb_val valid this cycle
- dmem_req  out  1  access request
- dmem_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
- dmem_write_en  out  1  store when 1
- dmem_be  out  DATA_W/8  byte enables
- dmem_val_out  out  DATA_W  lane-aligned store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid
- dmem_val_in  in  DATA_W  load data (full word)

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE, no memory op:
  - next edge: wb_val <= rd_val_passthrough, wb_valid <= 1
  - stall = 0
- IDLE, memory op, misaligned:
  - misaligned = half with addr[0]=1, word with addr[1:0]!=0, or size=11
  - no request; misalign = 1 and wb_valid = 0 for one cycle
  - stall = 0
- IDLE, memory op, aligned:
  - dmem_req = 1 combinationally, stall = 1
  - gnt=1: store goes to DONE, load goes to WAIT
  - gnt=0: go to REQ
- REQ: dmem_req = 1, with address, be, data and write_en held stable until gnt. stall = 1. Exit rules same as IDLE.
- WAIT: stall = 1. On rvalid, register the extracted load into wb_val and go to DONE.
- DONE: stall = 0, so the pipeline advances on this edge. The op is not re-issued. wb_valid = 1 for a load, 0 for a store. Next state: IDLE.
- Store lanes, offset o = addr[1:0]:
  - byte: data replicated ×4, be = 0001<<o
  - half: data replicated ×2, be = 0011<<o
  - word: be = 1111
- Load extract: dmem_val_in >> (8·o), truncated to size, then sign-extended unless ld_unsigned.
- wb_valid is 0 during stall cycles.

## Timing
- Reset value of every output is 0. State resets to IDLE.
- An rvalid or gnt arriving in IDLE or DONE is ignored. This includes stale responses after a mid-access reset.
- Non-memory op: 1-cycle latency, no stall.
- Load, gnt in issue cycle, rvalid one cycle later: stalled 2 cycles, DONE in cycle 3, wb_valid in cycle 3.
- Store, immediate gnt: stalled 1 cycle, DONE in cycle 2.
- Each cycle of gnt delay or rvalid delay adds one stall cycle. There is no timeout.
- dmem_req is never asserted in WAIT or DONE. At most one access is outstanding.

## Structure
- Shared package lsu_pkg:
  - size encodings (SZ_B, SZ_H, SZ_W)
  - state enum
  - function for the misalignment check
- Sub-module lsu_align (combinational): store lane replication and be generation, plus load extract and extend.
- Top level holds the FSM and the wb registers.

## Test plan
- Reset with memory zeroed; no memory op; rd_val=0x1234 -> next cycle wb_val=0x1234, wb_valid=1, stall=0.
- Store word 0xDEADBEEF to 0x10, gnt immediate -> be=1111, addr=0x10, 1 stall cycle. Then load word from 0x10, rvalid +1 -> wb_val=0xDEADBEEF.
- Byte lanes:
  - store byte 0x80 to 0x13 -> be=1000, dmem_val_out=0x80808080
  - load byte signed from 0x13 -> 0xFFFFFF80
  - load byte unsigned from 0x13 -> 0x00000080
- Load half from 0x11 -> misalign=1 for one cycle, no dmem_req, stall=0, wb_valid=0.
- Back-pressure:
  - gnt delayed 3 cycles and rvalid delayed 2 cycles -> stall held 6 cycles
  - request fields stable throughout REQ
  - exactly one wb_valid pulse
- Reset asserted in WAIT, then rvalid after release -> all outputs 0, state IDLE, rvalid ignored, no wb_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
//   Shared definitions for the load/store unit:
//     - access size encodings (SZ_B, SZ_H, SZ_W; 2'b11 is illegal)
//     - FSM state enum (exported on the lsu state_dbg port)
//     - is_misaligned(): alignment check for a size/offset pair
// -----------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } lsu_state_e;

  // A halfword must sit on an even address and a word on a multiple of four.
  // The reserved size encoding is treated as misaligned, so it never reaches
  // the memory.
  function automatic logic is_misaligned(input logic [1:0] sz,
                                         input logic [1:0] off);
    logic bad;
    case (sz)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// -----------------------------------------------------------------------------
// lsu_if
//   Data-memory bus between the load/store unit (master) and the memory
//   (slave).
//
//   Handshake:
//     - The master raises dmem_req with dmem_addr, dmem_write_en, dmem_be and
//       dmem_val_out, and holds all of them stable until the slave answers
//       with dmem_gnt in the same cycle. A cycle with dmem_req && dmem_gnt
//       transfers the request; dmem_req drops afterwards.
//     - For a read, the slave later pulses dmem_rvalid for exactly one cycle
//       with the full word on dmem_val_in. Writes get no response.
//     - At most one access is outstanding; gnt/rvalid seen while no access is
//       pending are ignored by the master.
//
//   Signals:
//     dmem_req      master->slave  access request
//     dmem_addr     master->slave  word-aligned byte address
//     dmem_write_en master->slave  1 = store
//     dmem_be       master->slave  byte enables
//     dmem_val_out  master->slave  lane-aligned store data
//     dmem_gnt      slave->master  request accepted this cycle
//     dmem_rvalid   slave->master  read data valid
//     dmem_val_in   slave->master  read data (full word)
// -----------------------------------------------------------------------------
interface lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  dmem_req;
  logic [ADDR_W-1:0]     dmem_addr;
  logic                  dmem_write_en;
  logic [DATA_W/8-1:0]   dmem_be;
  logic [DATA_W-1:0]     dmem_val_out;
  logic                  dmem_gnt;
  logic                  dmem_rvalid;
  logic [DATA_W-1:0]     dmem_val_in;

  modport master (
    output dmem_req,
    output dmem_addr,
    output dmem_write_en,
    output dmem_be,
    output dmem_val_out,
    input  dmem_gnt,
    input  dmem_rvalid,
    input  dmem_val_in
  );

  modport slave (
    input  dmem_req,
    input  dmem_addr,
    input  dmem_write_en,
    input  dmem_be,
    input  dmem_val_out,
    output dmem_gnt,
    output dmem_rvalid,
    output dmem_val_in
  );

endinterface

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
//   Combinational lane logic for the load/store unit (DATA_W must be 32).
//   Store side: replicates the store data across the lanes and builds the
//   byte enables from the size and the byte offset.
//   Load side: shifts the returned word down by the byte offset, truncates it
//   to the access size and sign- or zero-extends it.
//
//   Ports:
//     size        in   access size (SZ_B/SZ_H/SZ_W)
//     offset      in   byte offset within the word (addr[1:0])
//     ld_unsigned in   zero-extend loads when 1
//     st_data     in   raw store data
//     st_lanes    out  lane-replicated store data
//     st_be       out  byte enables (all zero for the illegal size)
//     ld_word     in   full word returned by memory
//     ld_result   out  extracted and extended load value
// -----------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]          size,
  input  logic [1:0]          offset,
  input  logic                ld_unsigned,
  input  logic [DATA_W-1:0]   st_data,
  output logic [DATA_W-1:0]   st_lanes,
  output logic [DATA_W/8-1:0] st_be,
  input  logic [DATA_W-1:0]   ld_word,
  output logic [DATA_W-1:0]   ld_result
);

  logic [DATA_W-1:0] shifted;
  logic              sign_b;
  logic              sign_h;

  always_comb begin
    // Bring the addressed byte/halfword down to bit 0.
    shifted = ld_word >> {offset, 3'b000};
    sign_b  = ~ld_unsigned & shifted[7];
    sign_h  = ~ld_unsigned & shifted[15];

    st_lanes  = st_data;
    st_be     = '0;
    ld_result = shifted;

    case (size)
      SZ_B: begin
        st_lanes  = {4{st_data[7:0]}};
        st_be     = 4'b0001 << offset;
        ld_result = {{24{sign_b}}, shifted[7:0]};
      end
      SZ_H: begin
        st_lanes  = {2{st_data[15:0]}};
        st_be     = 4'b0011 << offset;
        ld_result = {{16{sign_h}}, shifted[15:0]};
      end
      SZ_W: begin
        st_lanes  = st_data;
        st_be     = 4'b1111;
        ld_result = shifted;
      end
      default: begin
        st_lanes  = st_data;
        st_be     = '0;
        ld_result = shifted;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu
//   Load/store unit for the memory stage. Issues byte/half/word accesses over
//   the lsu_if bus, stalls the pipeline while an access is outstanding,
//   flags misaligned accesses and registers the writeback value.
//
//   Ports:
//     clk                   in   clock, rising edge
//     reset                 in   asynchronous, active-low
//     is_ld_op_passthrough  in   load in this stage
//     is_str_op_passthrough in   store in this stage
//     size                  in   00 byte, 01 half, 10 word, 11 illegal
//     ld_unsigned           in   zero-extend loads when 1
//     md_passthrough        in   byte address
//     rd_val_passthrough    in   store data, or result of a non-memory op
//     stall                 out  hold this stage's inputs and upstream
//     misalign              out  one-cycle fault pulse
//     wb_val                out  registered writeback value
//     wb_valid              out  wb_val valid this cycle
//     dmem                  master side of the data-memory bus
//     state_dbg             out  current FSM state
//
//   Flow: IDLE issues an aligned access combinationally. Without a grant the
//   request is parked in REQ; a granted load waits for rvalid in WAIT; every
//   access finishes with one DONE cycle in which stall drops so the pipeline
//   advances without re-issuing the op.
// -----------------------------------------------------------------------------
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              is_ld_op_passthrough,
  input  logic              is_str_op_passthrough,
  input  logic [1:0]        size,
  input  logic              ld_unsigned,
  input  logic [ADDR_W-1:0] md_passthrough,
  input  logic [DATA_W-1:0] rd_val_passthrough,
  output logic              stall,
  output logic              misalign,
  output logic [DATA_W-1:0] wb_val,
  output logic              wb_valid,
  lsu_if.master             dmem,
  output lsu_state_e        state_dbg
);

  lsu_state_e state_q;
  lsu_state_e state_d;

  // Request captured at issue; drives the bus in REQ and the extract in WAIT
  // so neither depends on the upstream honouring stall.
  logic [ADDR_W-1:0] lat_addr;
  logic [1:0]        lat_size;
  logic              lat_uns;
  logic              lat_load;
  logic [DATA_W-1:0] lat_data;

  logic              mem_op;
  logic              cur_mis;
  logic              issue;
  logic              req_live;

  logic [ADDR_W-1:0] cur_addr;
  logic [1:0]        cur_size;
  logic              cur_uns;
  logic              cur_load;
  logic [DATA_W-1:0] cur_data;

  logic [DATA_W-1:0]   st_lanes;
  logic [DATA_W/8-1:0] st_be;
  logic [DATA_W-1:0]   ld_result;

  // ---------------------------------------------------------------------------
  // Issue decode
  // ---------------------------------------------------------------------------
  assign mem_op  = is_ld_op_passthrough | is_str_op_passthrough;
  assign cur_mis = is_misaligned(size, md_passthrough[1:0]);
  assign issue   = (state_q == ST_IDLE) && mem_op && !cur_mis;

  // In IDLE the live pipeline inputs describe the access; afterwards the
  // captured copy does.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_addr = md_passthrough;
      cur_size = size;
      cur_uns  = ld_unsigned;
      cur_load = is_ld_op_passthrough;
      cur_data = rd_val_passthrough;
    end else begin
      cur_addr = lat_addr;
      cur_size = lat_size;
      cur_uns  = lat_uns;
      cur_load = lat_load;
      cur_data = lat_data;
    end
  end

  lsu_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .size        (cur_size),
    .offset      (cur_addr[1:0]),
    .ld_unsigned (cur_uns),
    .st_data     (cur_data),
    .st_lanes    (st_lanes),
    .st_be       (st_be),
    .ld_word     (dmem.dmem_val_in),
    .ld_result   (ld_result)
  );

  // ---------------------------------------------------------------------------
  // Bus and pipeline outputs. Gating with reset keeps every output at zero
  // while reset is held, whatever the pipeline inputs show.
  // ---------------------------------------------------------------------------
  assign req_live = issue || (state_q == ST_REQ);

  assign dmem.dmem_req      = reset && req_live;
  assign dmem.dmem_addr     = dmem.dmem_req ? {cur_addr[ADDR_W-1:2], 2'b00} : '0;
  assign dmem.dmem_write_en = dmem.dmem_req && !cur_load;
  assign dmem.dmem_be       = dmem.dmem_req ? st_be : '0;
  assign dmem.dmem_val_out  = dmem.dmem_write_en ? st_lanes : '0;

  assign stall     = reset && (issue || (state_q == ST_REQ) || (state_q == ST_WAIT));
  assign state_dbg = state_q;

  // ---------------------------------------------------------------------------
  // FSM next state. gnt is only looked at while a request is on the bus and
  // rvalid only in WAIT, so stray responses in IDLE/DONE are dropped.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          if (dmem.dmem_gnt) begin
            state_d = is_ld_op_passthrough ? ST_WAIT : ST_DONE;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (dmem.dmem_gnt) begin
          state_d = lat_load ? ST_WAIT : ST_DONE;
        end
      end
      ST_WAIT: begin
        if (dmem.dmem_rvalid) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, captured request and writeback registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      lat_addr <= '0;
      lat_size <= '0;
      lat_uns  <= 1'b0;
      lat_load <= 1'b0;
      lat_data <= '0;
      wb_val   <= '0;
      wb_valid <= 1'b0;
      misalign <= 1'b0;
    end else begin
      state_q <= state_d;

      if (issue) begin
        lat_addr <= md_passthrough;
        lat_size <= size;
        lat_uns  <= ld_unsigned;
        lat_load <= is_ld_op_passthrough;
        lat_data <= rd_val_passthrough;
      end

      // Writeback is only valid the cycle after a non-memory op or in the
      // DONE cycle of a load; every other cycle clears it.
      wb_valid <= 1'b0;
      misalign <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (!mem_op) begin
            wb_val   <= rd_val_passthrough;
            wb_valid <= 1'b1;
          end else if (cur_mis) begin
            misalign <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (dmem.dmem_rvalid) begin
            wb_val   <= ld_result;
            wb_valid <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu
//   Self-checking bench for lsu. A table of single-access vectors (with gnt and
//   rvalid latencies) is replayed by a driver task that checks the bus fields,
//   stall count and DONE behaviour; writeback values go through a scoreboard
//   queue popped whenever wb_valid is seen. Hand-written sequences cover the
//   misalignment pulse and a reset in the middle of an access.
// -----------------------------------------------------------------------------
module tb_lsu;
  import lsu_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        is_ld;
  logic        is_st;
  logic [1:0]  size;
  logic        ld_unsigned;
  logic [31:0] md;
  logic [31:0] rd_val;
  logic        stall;
  logic        misalign;
  logic [31:0] wb_val;
  logic        wb_valid;
  lsu_state_e  state_dbg;

  lsu_if #(.ADDR_W(32), .DATA_W(32)) dmem_bus ();

  lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .is_ld_op_passthrough  (is_ld),
    .is_str_op_passthrough (is_st),
    .size                  (size),
    .ld_unsigned           (ld_unsigned),
    .md_passthrough        (md),
    .rd_val_passthrough    (rd_val),
    .stall                 (stall),
    .misalign              (misalign),
    .wb_val                (wb_val),
    .wb_valid              (wb_valid),
    .dmem                  (dmem_bus),
    .state_dbg             (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_wb;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wb_unexpected: got wb_valid=1 wb_val=%08h expected no writeback at %0t",
                 wb_val, $time);
      end else begin
        exp_wb = exp_q.pop_front();
        check("wb_val", wb_val, exp_wb);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        ld;
    logic        st;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] mem;
    int          gnt_dly;
    int          rv_lat;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] wb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ld, input logic st, input logic [1:0] sz,
                              input logic uns, input logic [31:0] addr,
                              input logic [31:0] data, input logic [31:0] mem,
                              input int gnt_dly, input int rv_lat, input logic mis,
                              input logic [3:0] be, input logic [31:0] wdata,
                              input logic [31:0] wb);
    vec_t v;
    v.ld = ld; v.st = st; v.sz = sz; v.uns = uns; v.addr = addr; v.data = data;
    v.mem = mem; v.gnt_dly = gnt_dly; v.rv_lat = rv_lat; v.mis = mis;
    v.be = be; v.wdata = wdata; v.wb = wb;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop(input logic [31:0] val);
    is_ld = 1'b0; is_st = 1'b0; size = SZ_W; ld_unsigned = 1'b0;
    md = 32'h0; rd_val = val;
  endtask

  // Entered and left one time unit after a rising edge.
  task automatic run_op(input vec_t v, input int idx);
    int c;
    int stalls;
    bit granted;
    int w;
    bit done;
    logic [31:0] exp_addr;
    string tag;
    tag = $sformatf("v%0d", idx);

    is_ld = v.ld; is_st = v.st; size = v.sz; ld_unsigned = v.uns;
    md = v.addr; rd_val = v.data;
    dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0;

    if (!(v.ld || v.st)) begin
      exp_q.push_back(v.data);
      #1;
      check({tag, "_nop_stall"}, stall, 0);
      check({tag, "_nop_req"}, dmem_bus.dmem_req, 0);
      tick();
      return;
    end

    if (v.mis) begin
      #1;
      check({tag, "_mis_stall"}, stall, 0);
      check({tag, "_mis_req"}, dmem_bus.dmem_req, 0);
      tick();
      check({tag, "_mis_pulse"}, misalign, 1);
      check({tag, "_mis_wbv"}, wb_valid, 0);
      drive_nop($urandom);
      exp_q.push_back(rd_val);
      tick();
      check({tag, "_mis_end"}, misalign, 0);
      return;
    end

    exp_addr = v.addr & 32'hFFFF_FFFC;
    c = 0; stalls = 0; granted = 0; w = 0; done = 0;
    while (!done && c < 64) begin
      dmem_bus.dmem_gnt    = !granted && (c == v.gnt_dly);
      dmem_bus.dmem_rvalid = granted && v.ld && (w == v.rv_lat);
      dmem_bus.dmem_val_in = dmem_bus.dmem_rvalid ? v.mem : $urandom;
      if (dmem_bus.dmem_rvalid) exp_q.push_back(v.wb);
      #1;
      if (stall) stalls++;
      if (stall && c > 0) check({tag, "_wbv_in_stall"}, wb_valid, 0);
      if (!granted) begin
        check({tag, "_req"}, dmem_bus.dmem_req, 1);
        check({tag, "_addr"}, dmem_bus.dmem_addr, exp_addr);
        check({tag, "_be"}, dmem_bus.dmem_be, v.be);
        check({tag, "_we"}, dmem_bus.dmem_write_en, v.st);
        if (v.st) check({tag, "_wdata"}, dmem_bus.dmem_val_out, v.wdata);
      end else begin
        check({tag, "_req_off"}, dmem_bus.dmem_req, 0);
      end
      if (!stall) begin
        check({tag, "_done_state"}, state_dbg, ST_DONE);
        check({tag, "_done_wbv"}, wb_valid, v.ld);
        done = 1;
      end
      if (dmem_bus.dmem_gnt) granted = 1;
      if (granted) w++;
      c++;
      tick();
    end
    dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no DONE within 64 cycles expected DONE", tag);
    end
    check({tag, "_stalls"}, stalls, v.gnt_dly + 1 + (v.ld ? v.rv_lat : 0));
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    //              ld st sz    uns addr          data          mem           gd rl mis be       wdata         wb
    vecs.push_back(mk(0, 0, SZ_W, 0, 32'h0,        32'h0000_1234, 32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0000_1234));
    vecs.push_back(mk(0, 1, SZ_W, 0, 32'h10,       32'hDEAD_BEEF, 32'h0,        0, 0, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0));
    vecs.push_back(mk(1, 0, SZ_W, 0, 32'h10,       32'h0,        32'hDEAD_BEEF, 0, 1, 0, 4'b1111, 32'h0,        32'hDEAD_BEEF));
    vecs.push_back(mk(0, 1, SZ_B, 0, 32'h13,       32'h0000_0080, 32'h0,        0, 0, 0, 4'b1000, 32'h8080_8080, 32'h0));
    vecs.push_back(mk(1, 0, SZ_B, 0, 32'h13,       32'h0,        32'h80AD_BEEF, 0, 1, 0, 4'b1000, 32'h0,        32'hFFFF_FF80));
    vecs.push_back(mk(1, 0, SZ_B, 1, 32'h13,       32'h0,        32'h80AD_BEEF, 0, 1, 0, 4'b1000, 32'h0,        32'h0000_0080));
    vecs.push_back(mk(1, 0, SZ_H, 0, 32'h11,       32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(0, 1, SZ_H, 0, 32'h22,       32'h0000_A5C3, 32'h0,        0, 0, 0, 4'b1100, 32'hA5C3_A5C3, 32'h0));
    vecs.push_back(mk(1, 0, SZ_H, 0, 32'h22,       32'h0,        32'hA5C3_1234, 0, 1, 0, 4'b1100, 32'h0,        32'hFFFF_A5C3));
    vecs.push_back(mk(1, 0, SZ_H, 1, 32'h22,       32'h0,        32'hA5C3_1234, 0, 1, 0, 4'b1100, 32'h0,        32'h0000_A5C3));
    vecs.push_back(mk(1, 0, SZ_B, 0, 32'h21,       32'h0,        32'h0000_7F00, 0, 1, 0, 4'b0010, 32'h0,        32'h0000_007F));
    vecs.push_back(mk(1, 0, SZ_W, 0, 32'h06,       32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 2'b11, 0, 32'h20,      32'h1111_2222, 32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(1, 0, SZ_W, 0, 32'h44,       32'h0,        32'hCAFE_F00D, 3, 2, 0, 4'b1111, 32'h0,        32'hCAFE_F00D));
    vecs.push_back(mk(0, 1, SZ_B, 0, 32'h31,       32'h1234_5678, 32'h0,        2, 0, 0, 4'b0010, 32'h7878_7878, 32'h0));
    vecs.push_back(mk(0, 0, SZ_W, 0, 32'h0,        32'hA5A5_0F0F, 32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'hA5A5_0F0F));

    reset = 1'b0;
    drive_nop(32'h0);
    dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_val_in = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", stall, 0);
    check("rst_wbv", wb_valid, 0);
    check("rst_wb_val", wb_val, 0);
    check("rst_req", dmem_bus.dmem_req, 0);
    check("rst_state", state_dbg, ST_IDLE);
    reset = 1'b1;

    foreach (vecs[i]) run_op(vecs[i], i);

    // Reset while a load waits for its data; the late rvalid must be dropped.
    is_ld = 1'b1; is_st = 1'b0; size = SZ_W; ld_unsigned = 1'b0;
    md = 32'h50; rd_val = 32'h0;
    dmem_bus.dmem_gnt = 1'b1;
    tick();
    dmem_bus.dmem_gnt = 1'b0;
    check("rw_state_wait", state_dbg, ST_WAIT);
    check("rw_stall", stall, 1);
    #1;
    reset = 1'b0;
    #1;
    check("rw_stall0", stall, 0);
    check("rw_mis0", misalign, 0);
    check("rw_wbval0", wb_val, 0);
    check("rw_wbv0", wb_valid, 0);
    check("rw_req0", dmem_bus.dmem_req, 0);
    check("rw_addr0", dmem_bus.dmem_addr, 0);
    check("rw_be0", dmem_bus.dmem_be, 0);
    check("rw_we0", dmem_bus.dmem_write_en, 0);
    check("rw_wdata0", dmem_bus.dmem_val_out, 0);
    check("rw_state0", state_dbg, ST_IDLE);
    tick();
    // Misaligned op keeps the stage from producing a writeback of its own.
    is_ld = 1'b1; size = SZ_H; md = 32'h11;
    reset = 1'b1;
    dmem_bus.dmem_rvalid = 1'b1;
    dmem_bus.dmem_val_in = 32'hBAD0_BAD0;
    #1;
    check("rw_post_state", state_dbg, ST_IDLE);
    check("rw_post_req", dmem_bus.dmem_req, 0);
    check("rw_post_stall", stall, 0);
    tick();
    dmem_bus.dmem_rvalid = 1'b0;
    check("rw_post_wbv", wb_valid, 0);
    check("rw_post_wbval", wb_val, 0);
    check("rw_post_state2", state_dbg, ST_IDLE);
    drive_nop(32'h0000_600D);
    exp_q.push_back(32'h0000_600D);
    tick();
    drive_nop(32'h0);
    exp_q.push_back(32'h0);
    tick();
    #5;
    check("sb_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
